// File: rtl/transpose_seq_ctrl_8x8.sv
// Sequencer for the 8x8 transpose buffer between the row and column DCT passes.
// Fills the buffer with 8 rows, then drains 8 columns into a registered valid/ready stage.
module transpose_seq_ctrl_8x8 #(
    parameter int DATA_WIDTH = 18
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         enable_write,
    output logic                         enable_read,
    output logic                         direction,
    input  logic signed [DATA_WIDTH-1:0] buf_out_0,
    input  logic signed [DATA_WIDTH-1:0] buf_out_1,
    input  logic signed [DATA_WIDTH-1:0] buf_out_2,
    input  logic signed [DATA_WIDTH-1:0] buf_out_3,
    input  logic signed [DATA_WIDTH-1:0] buf_out_4,
    input  logic signed [DATA_WIDTH-1:0] buf_out_5,
    input  logic signed [DATA_WIDTH-1:0] buf_out_6,
    input  logic signed [DATA_WIDTH-1:0] buf_out_7,
    output logic signed [DATA_WIDTH-1:0] out_0,
    output logic signed [DATA_WIDTH-1:0] out_1,
    output logic signed [DATA_WIDTH-1:0] out_2,
    output logic signed [DATA_WIDTH-1:0] out_3,
    output logic signed [DATA_WIDTH-1:0] out_4,
    output logic signed [DATA_WIDTH-1:0] out_5,
    output logic signed [DATA_WIDTH-1:0] out_6,
    output logic signed [DATA_WIDTH-1:0] out_7,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         err_frame
);

    localparam logic [0:0] ST_WRITE = 1'b0;
    localparam logic [0:0] ST_READ  = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] row_cnt_q, row_cnt_d;
    logic [2:0] col_cnt_q, col_cnt_d;
    logic       direction_q, direction_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       err_frame_q, err_frame_d;

    logic       slot_free;
    logic       load;

    logic signed [DATA_WIDTH-1:0] buf_col [8];
    logic signed [DATA_WIDTH-1:0] out_q   [8];

    assign buf_col[0] = buf_out_0;
    assign buf_col[1] = buf_out_1;
    assign buf_col[2] = buf_out_2;
    assign buf_col[3] = buf_out_3;
    assign buf_col[4] = buf_out_4;
    assign buf_col[5] = buf_out_5;
    assign buf_col[6] = buf_out_6;
    assign buf_col[7] = buf_out_7;

    assign out_0 = out_q[0];
    assign out_1 = out_q[1];
    assign out_2 = out_q[2];
    assign out_3 = out_q[3];
    assign out_4 = out_q[4];
    assign out_5 = out_q[5];
    assign out_6 = out_q[6];
    assign out_7 = out_q[7];

    assign direction = direction_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err_frame = err_frame_q;

    // The output slot can take a new column when empty or being drained this cycle.
    assign slot_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        col_cnt_d    = col_cnt_q;
        direction_d  = direction_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        err_frame_d  = err_frame_q;
        in_ready     = 1'b0;
        enable_write = 1'b0;
        enable_read  = 1'b0;
        load         = 1'b0;

        if (state_q == ST_WRITE) begin
            in_ready     = 1'b1;
            enable_write = in_valid;
            if (in_valid) begin
                // Framing is only flagged; the block length is fixed at 8 rows regardless.
                if (in_last != (row_cnt_q == 3'd7)) begin
                    err_frame_d = 1'b1;
                end
                if (row_cnt_q == 3'd7) begin
                    row_cnt_d = 3'd0;
                    state_d   = ST_READ;
                end else begin
                    row_cnt_d = row_cnt_q + 3'd1;
                end
            end
        end else begin
            if (slot_free) begin
                load        = 1'b1;
                enable_read = 1'b1;
                if (col_cnt_q == 3'd7) begin
                    col_cnt_d   = 3'd0;
                    direction_d = ~direction_q;
                    state_d     = ST_WRITE;
                end else begin
                    col_cnt_d = col_cnt_q + 3'd1;
                end
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = (col_cnt_q == 3'd7);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WRITE;
            row_cnt_q   <= 3'd0;
            col_cnt_q   <= 3'd0;
            direction_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            direction_q <= direction_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_frame_q <= err_frame_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_out
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                out_q[gi] <= '0;
            end else if (load) begin
                out_q[gi] <= buf_col[gi];
            end
        end
    end

endmodule

// File: tb/tb_transpose_seq_ctrl_8x8.sv
// Directed bench for transpose_seq_ctrl_8x8: fill/drain sequencing, stalls, framing, reset.
module tb_transpose_seq_ctrl_8x8;
    localparam int DW = 18;

    logic clock     = 1'b0;
    logic reset     = 1'b1;
    logic in_valid  = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, enable_write, enable_read, direction;
    logic out_valid, out_last, err_frame;
    logic [DW-1:0] bufv [8];
    logic [DW-1:0] obs  [8];

    int checks   = 0;
    int failures = 0;
    int er_cnt;
    int col;
    int rdy    [11] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    int exp_er [11] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};

    always #5 clock = ~clock;

    transpose_seq_ctrl_8x8 #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .enable_write(enable_write), .enable_read(enable_read), .direction(direction),
        .buf_out_0(bufv[0]), .buf_out_1(bufv[1]), .buf_out_2(bufv[2]), .buf_out_3(bufv[3]),
        .buf_out_4(bufv[4]), .buf_out_5(bufv[5]), .buf_out_6(bufv[6]), .buf_out_7(bufv[7]),
        .out_0(obs[0]), .out_1(obs[1]), .out_2(obs[2]), .out_3(obs[3]),
        .out_4(obs[4]), .out_5(obs[5]), .out_6(obs[6]), .out_7(obs[7]),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err_frame(err_frame)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int blk, input int c, input int k);
        logic [DW-1:0] v;
        v = DW'((blk << 8) | (c << 4) | k);
        if ((k % 2) == 1) v[DW-1] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_col(input int blk, input int c);
        for (int k = 0; k < 8; k++) bufv[k] = val(blk, c, k);
    endtask

    task automatic chk_col(input string tag, input int blk, input int c);
        for (int k = 0; k < 8; k++) check(tag, 32'(obs[k]), 32'(val(blk, c, k)));
        $display("column blk=%0d col=%0d out_0=0x%0h out_last=%0b", blk, c, obs[0], out_last);
    endtask

    task automatic write_rows(input string tag, input int last_at);
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            in_last  = (r == last_at);
            #1;
            check({tag, "_ew"}, 32'(enable_write), 1);
            check({tag, "_in_ready"}, 32'(in_ready), 1);
            check({tag, "_er_low"}, 32'(enable_read), 0);
            tick();
            $display("row accepted tag=%s row=%0d in_last=%0b", tag, r, in_last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic read_cols(input string tag, input int blk);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            set_col(blk, c);
            #1;
            check({tag, "_er"}, 32'(enable_read), 1);
            check({tag, "_ready_low"}, 32'(in_ready), 0);
            check({tag, "_ew_low"}, 32'(enable_write), 0);
            tick();
            check({tag, "_valid"}, 32'(out_valid), 1);
            check({tag, "_last"}, 32'(out_last), 32'(c == 7));
            chk_col({tag, "_data"}, blk, c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 8; k++) bufv[k] = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_direction", 32'(direction), 0);
        check("rst_err_frame", 32'(err_frame), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_0", 32'(obs[0]), 0);
        check("rst_er", 32'(enable_read), 0);
        reset = 1'b0;

        // Block 1: plain write then read, no stalls
        write_rows("t1w", 7);
        check("t1_dir_before", 32'(direction), 0);
        read_cols("t1r", 1);
        check("t1_dir_after", 32'(direction), 1);
        check("t1_back_to_write", 32'(in_ready), 1);
        #1;
        check("t1_no_read_in_write", 32'(enable_read), 0);
        tick();
        check("t1_drained_valid", 32'(out_valid), 0);
        check("t1_drained_last", 32'(out_last), 0);

        // Block 2: read phase under out_ready pattern 1,0,0,1,0,1,1,1,1,1,1
        write_rows("t2w", 7);
        col = 0;
        er_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            out_ready = rdy[i][0];
            set_col(2, col);
            #1;
            check("t2_er", 32'(enable_read), 32'(exp_er[i]));
            check("t2_ew_low", 32'(enable_write), 0);
            if (enable_read) er_cnt++;
            tick();
            if (exp_er[i] != 0) col++;
            check("t2_valid", 32'(out_valid), 1);
            check("t2_last", 32'(out_last), 32'(col == 8));
            chk_col("t2_data", 2, col - 1);
        end
        check("t2_er_count", 32'(er_cnt), 8);
        check("t2_back_to_write", 32'(in_ready), 1);
        check("t2_dir", 32'(direction), 0);

        // Blocks A and B with in_valid held high
        out_ready = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            in_valid = (i < 32);
            in_last  = (i == 7 || i == 23);
            set_col(3, i % 8);
            #1;
            check("t3_in_ready", 32'(in_ready), 32'(((i / 8) % 2) == 0));
            check("t3_ew", 32'(enable_write), 32'(((i / 8) % 2) == 0 && i < 32));
            check("t3_er", 32'(enable_read), 32'(((i / 8) % 2) == 1));
            check("t3_dir", 32'(direction), 32'(i >= 16 && i < 32));
            tick();
            if (i == 0) check("t3_drain_with_accept", 32'(out_valid), 0);
            if (((i / 8) % 2) == 1) begin
                check("t3_col_valid", 32'(out_valid), 1);
                check("t3_col_data", 32'(obs[0]), 32'(val(3, i % 8, 0)));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Framing error: in_last on row 3
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            in_last  = (r == 3);
            #1;
            check("t4_ew", 32'(enable_write), 1);
            tick();
            check("t4_err", 32'(err_frame), 32'(r >= 3));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t4_in_read", 32'(in_ready), 0);
        read_cols("t4r", 4);
        check("t4_err_sticky", 32'(err_frame), 1);
        check("t4_dir", 32'(direction), 1);
        out_ready = 1'b0;
        tick();
        check("t4_held", 32'(out_valid), 1);

        // Reset after 5 rows accepted
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            #1;
            check("t5_pre_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        check("t5_pre_valid", 32'(out_valid), 1);
        check("t5_pre_dir", 32'(direction), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(out_valid), 0);
        check("t5_async_ready", 32'(in_ready), 1);
        check("t5_async_dir", 32'(direction), 0);
        check("t5_async_err", 32'(err_frame), 0);
        check("t5_async_out0", 32'(obs[0]), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        write_rows("t5w", 7);
        check("t5_full_block", 32'(in_ready), 0);
        check("t5_err_clean", 32'(err_frame), 0);

        // out_ready low through the read phase
        out_ready = 1'b0;
        set_col(6, 0);
        #1;
        check("t6_first_er", 32'(enable_read), 1);
        er_cnt = 1;
        tick();
        check("t6_valid", 32'(out_valid), 1);
        chk_col("t6_col0", 6, 0);
        for (int i = 0; i < 9; i++) begin
            set_col(6, 1);
            #1;
            check("t6_stall_er", 32'(enable_read), 0);
            check("t6_stall_state", 32'(in_ready), 0);
            tick();
            check("t6_hold_valid", 32'(out_valid), 1);
            check("t6_hold_data", 32'(obs[0]), 32'(val(6, 0, 0)));
        end
        out_ready = 1'b1;
        for (int c = 1; c < 8; c++) begin
            set_col(6, c);
            #1;
            check("t6_er", 32'(enable_read), 1);
            if (enable_read) er_cnt++;
            tick();
            check("t6_last", 32'(out_last), 32'(c == 7));
            chk_col("t6_data", 6, c);
        end
        check("t6_er_count", 32'(er_cnt), 8);
        check("t6_back_to_write", 32'(in_ready), 1);
        check("t6_dir", 32'(direction), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
